// File: rtl/branch_resolve.sv
// branch_resolve: DLX ID-stage branch evaluation and fetch redirect; DLX_DELAY_SLOT_EN ties FLUSH low
module branch_resolve #(
   parameter int DPFLAG = 0,
   parameter     GROUP  = "AUTO"
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        BR_VALID,
   input  logic [2:0]  BR_COND,
   input  logic [25:0] BR_OFFSET,
   input  logic [31:0] PC_PLUS4,
   input  logic        OPND_RDY,
   input  logic        A_LT,
   input  logic        A_LE,
   input  logic        A_GT,
   input  logic        A_GE,
   input  logic        A_EQ,
   input  logic        A_NE,
   input  logic        KILL,
   input  logic        REDIR_READY,
   output logic        BR_READY,
   output logic        REDIR_VALID,
   output logic [31:0] REDIR_PC,
   output logic        TAKEN,
   output logic        FLUSH,
   output logic        BR_ERR
);
   typedef enum logic [1:0] {IDLE, WAIT, REDIR} state_t;
   state_t      state_q, state_d;
   logic [2:0]  cond_q, cond_d, cond;
   logic [25:0] off_q, off_d, off;
   logic [31:0] pc4_q, pc4_d, pc4, redir_pc_q, redir_pc_d, target;
   logic        taken_q, taken_d, flush_q, flush_d, err_q, err_d, hit, accept;
   // Select live or latched branch fields, resolve the condition and form the target
   always_comb begin
      cond   = (state_q == WAIT) ? cond_q : BR_COND;
      off    = (state_q == WAIT) ? off_q : BR_OFFSET;
      pc4    = (state_q == WAIT) ? pc4_q : PC_PLUS4;
      hit    = (cond == 3'b000) ? A_EQ :
               (cond == 3'b001) ? A_NE :
               (cond == 3'b010) ? A_LT :
               (cond == 3'b011) ? A_LE :
               (cond == 3'b100) ? A_GT :
               (cond == 3'b101) ? A_GE :
               (cond == 3'b110);
      target = pc4 + ((cond == 3'b110) ? {{6{off[25]}}, off} : {{16{off[15]}}, off[15:0]});
      accept = !KILL && OPND_RDY && ((state_q == IDLE && BR_VALID) || state_q == WAIT);
   end
   // Next state, operand-wait latches and the one-cycle result pulses
   always_comb begin
      state_d    = state_q;
      cond_d     = cond_q;
      off_d      = off_q;
      pc4_d      = pc4_q;
      redir_pc_d = redir_pc_q;
      taken_d    = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: if (BR_VALID && !KILL && !OPND_RDY) begin
            state_d = WAIT;
            cond_d  = BR_COND;
            off_d   = BR_OFFSET;
            pc4_d   = PC_PLUS4;
         end
         WAIT: if (KILL) state_d = IDLE;
         REDIR: if (KILL || REDIR_READY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         taken_d = hit;
         err_d   = (cond == 3'b111);
         state_d = hit ? REDIR : IDLE;
         if (hit) redir_pc_d = target;
      end
`ifdef DLX_DELAY_SLOT_EN
      flush_d = 1'b0;
`else
      flush_d = taken_d;
`endif
   end
   // State and output registers, cleared asynchronously
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         cond_q     <= '0;
         off_q      <= '0;
         pc4_q      <= '0;
         redir_pc_q <= '0;
         taken_q    <= 1'b0;
         flush_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cond_q     <= cond_d;
         off_q      <= off_d;
         pc4_q      <= pc4_d;
         redir_pc_q <= redir_pc_d;
         taken_q    <= taken_d;
         flush_q    <= flush_d;
         err_q      <= err_d;
      end
   end
   assign BR_READY    = accept;
   assign REDIR_VALID = (state_q == REDIR);
   assign REDIR_PC    = redir_pc_q;
   assign TAKEN       = taken_q;
   assign FLUSH       = flush_q;
   assign BR_ERR      = err_q;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: scoreboard bench for branch_resolve
module tb_branch_resolve;
   logic        CLK, RESET_N, BR_VALID, OPND_RDY, KILL, REDIR_READY;
   logic [2:0]  BR_COND;
   logic [25:0] BR_OFFSET;
   logic [31:0] PC_PLUS4, REDIR_PC;
   logic        A_LT, A_LE, A_GT, A_GE, A_EQ, A_NE;
   logic        BR_READY, REDIR_VALID, TAKEN, FLUSH, BR_ERR;
   int          checks = 0, errors = 0;
   logic        pend;
`ifdef DLX_DELAY_SLOT_EN
   localparam bit FL = 1'b0;
`else
   localparam bit FL = 1'b1;
`endif
   localparam logic [5:0] POS = 6'b001101, NEG = 6'b110001, ZER = 6'b010110;
   typedef struct {
      logic        t;
      logic        e;
      logic [31:0] pc;
   } exp_t;
   exp_t q[$];

   branch_resolve dut (
      .CLK(CLK), .RESET_N(RESET_N), .BR_VALID(BR_VALID), .BR_COND(BR_COND),
      .BR_OFFSET(BR_OFFSET), .PC_PLUS4(PC_PLUS4), .OPND_RDY(OPND_RDY),
      .A_LT(A_LT), .A_LE(A_LE), .A_GT(A_GT), .A_GE(A_GE), .A_EQ(A_EQ), .A_NE(A_NE),
      .KILL(KILL), .REDIR_READY(REDIR_READY), .BR_READY(BR_READY),
      .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC), .TAKEN(TAKEN),
      .FLUSH(FLUSH), .BR_ERR(BR_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_br(input logic t, input logic e, input logic [31:0] pc);
      exp_t x;
      x.t  = t;
      x.e  = e;
      x.pc = pc;
      q.push_back(x);
   endtask

   task automatic drive(input logic v, input logic r, input logic [2:0] c,
                        input logic [25:0] o, input logic [31:0] p, input logic [5:0] f);
      BR_VALID  = v;
      OPND_RDY  = r;
      BR_COND   = c;
      BR_OFFSET = o;
      PC_PLUS4  = p;
      {A_LT, A_LE, A_GT, A_GE, A_EQ, A_NE} = f;
   endtask

   task automatic br(input logic [2:0] c, input logic [25:0] o, input logic [31:0] p,
                     input logic [5:0] f, input logic et, input logic ee, input logic [31:0] ep);
      expect_br(et, ee, ep);
      drive(1'b1, 1'b1, c, o, p, f);
      @(negedge CLK);
      chk("br_ready", BR_READY, 1);
      cyc();
      drive(1'b0, 1'b0, 3'b000, 26'h0, 32'h0, 6'h0);
      if (et) begin
         REDIR_READY = 1'b1;
         cyc();
         REDIR_READY = 1'b0;
      end
      @(negedge CLK);
      chk("idle_after", REDIR_VALID, 0);
      cyc();
   endtask

   initial begin
      exp_t x;
      pend = 1'b0;
      forever begin
         @(negedge CLK);
         if (pend) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard: result with no expectation queued");
            end else begin
               x = q.pop_front();
               chk("taken", TAKEN, x.t);
               chk("flush", FLUSH, x.t & FL);
               chk("br_err", BR_ERR, x.e);
               chk("redir_valid", REDIR_VALID, x.t);
               if (x.t) chk("redir_pc", REDIR_PC, x.pc);
            end
         end else
            chk("no_pulse", {TAKEN, FLUSH, BR_ERR}, 0);
         pend = BR_READY;
      end
   end

   initial begin
      RESET_N = 1'b0;
      KILL = 1'b0;
      REDIR_READY = 1'b0;
      drive(1'b0, 1'b0, 3'b000, 26'h0, 32'h0, 6'h0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_redir_valid", REDIR_VALID, 0);
      chk("rst_redir_pc", REDIR_PC, 0);
      chk("rst_pulses", {TAKEN, FLUSH, BR_ERR}, 0);
      cyc();
      RESET_N = 1'b1;
      cyc();
      // condition codes and target arithmetic
      br(3'b000, 26'h0000010, 32'h00000100, ZER, 1, 0, 32'h00000110);
      br(3'b010, 26'h0000010, 32'h00000100, POS, 0, 0, 32'h0);
      br(3'b010, 26'h000FFFC, 32'h00000002, NEG, 1, 0, 32'hFFFFFFFE);
      br(3'b001, 26'h3FF0008, 32'h00001000, POS, 1, 0, 32'h00001008);
      br(3'b011, 26'h0000008, 32'h00000040, ZER, 1, 0, 32'h00000048);
      br(3'b100, 26'h0000008, 32'h00000040, ZER, 0, 0, 32'h0);
      br(3'b101, 26'h0007FFF, 32'hFFFFFFF0, POS, 1, 0, 32'h00007FEF);
      br(3'b110, 26'h3FFFFF0, 32'h00000010, 6'h00, 1, 0, 32'h00000000);
      br(3'b110, 26'h0008000, 32'h00000100, 6'h00, 1, 0, 32'h00008100);
      br(3'b000, 26'h0000008, 32'h00000040, NEG, 0, 0, 32'h0);
      br(3'b001, 26'h0000008, 32'h00000040, ZER, 0, 0, 32'h0);
      br(3'b111, 26'h0000008, 32'h00000040, 6'h3F, 0, 1, 32'h0);
      // operand late by three cycles, live inputs changed after latch
      expect_br(1, 0, 32'h00000420);
      drive(1'b1, 1'b0, 3'b000, 26'h20, 32'h400, 6'h00);
      @(negedge CLK);
      chk("wait_ready_1", BR_READY, 0);
      cyc();
      drive(1'b0, 1'b0, 3'b001, 26'h99, 32'h9000, 6'b000001);
      repeat (2) begin
         @(negedge CLK);
         chk("wait_ready_n", BR_READY, 0);
         cyc();
      end
      drive(1'b0, 1'b1, 3'b001, 26'h99, 32'h9000, ZER);
      @(negedge CLK);
      chk("wait_accept", BR_READY, 1);
      cyc();
      drive(1'b0, 1'b0, 3'b000, 26'h0, 32'h0, 6'h00);
      REDIR_READY = 1'b1;
      cyc();
      REDIR_READY = 1'b0;
      cyc();
      // redirect held five cycles with a new branch waiting
      expect_br(1, 0, 32'h00000840);
      drive(1'b1, 1'b1, 3'b110, 26'h40, 32'h800, 6'h00);
      @(negedge CLK);
      chk("hold_accept", BR_READY, 1);
      cyc();
      expect_br(1, 0, 32'h00000014);
      drive(1'b1, 1'b1, 3'b001, 26'h4, 32'h10, POS);
      repeat (5) begin
         @(negedge CLK);
         chk("stall_ready", BR_READY, 0);
         chk("stall_valid", REDIR_VALID, 1);
         chk("stall_pc", REDIR_PC, 32'h840);
         cyc();
      end
      REDIR_READY = 1'b1;
      @(negedge CLK);
      chk("hs_ready", BR_READY, 0);
      cyc();
      REDIR_READY = 1'b0;
      @(negedge CLK);
      chk("reaccept_ready", BR_READY, 1);
      chk("reaccept_valid", REDIR_VALID, 0);
      cyc();
      drive(1'b0, 1'b0, 3'b000, 26'h0, 32'h0, 6'h00);
      REDIR_READY = 1'b1;
      cyc();
      REDIR_READY = 1'b0;
      cyc();
      // KILL in REDIR, with and without a simultaneous handshake
      for (int i = 0; i < 2; i++) begin
         expect_br(1, 0, 32'h00000204);
         drive(1'b1, 1'b1, 3'b000, 26'h4, 32'h200, ZER);
         @(negedge CLK);
         chk("kr_accept", BR_READY, 1);
         cyc();
         drive(1'b0, 1'b0, 3'b000, 26'h0, 32'h0, 6'h00);
         KILL = 1'b1;
         REDIR_READY = (i == 0);
         @(negedge CLK);
         chk("kr_ready", BR_READY, 0);
         cyc();
         KILL = 1'b0;
         REDIR_READY = 1'b0;
         @(negedge CLK);
         chk("kr_valid", REDIR_VALID, 0);
         cyc();
      end
      // KILL in IDLE blocks acceptance
      KILL = 1'b1;
      drive(1'b1, 1'b1, 3'b000, 26'h4, 32'h200, ZER);
      @(negedge CLK);
      chk("ki_ready", BR_READY, 0);
      cyc();
      KILL = 1'b0;
      drive(1'b0, 1'b0, 3'b000, 26'h0, 32'h0, 6'h00);
      @(negedge CLK);
      chk("ki_valid", REDIR_VALID, 0);
      cyc();
      // KILL in WAIT beats a ready operand
      drive(1'b1, 1'b0, 3'b000, 26'h4, 32'h200, 6'h00);
      @(negedge CLK);
      chk("kw_ready0", BR_READY, 0);
      cyc();
      drive(1'b0, 1'b1, 3'b000, 26'h4, 32'h200, ZER);
      KILL = 1'b1;
      @(negedge CLK);
      chk("kw_ready", BR_READY, 0);
      cyc();
      KILL = 1'b0;
      @(negedge CLK);
      chk("kw_idle", BR_READY, 0);
      chk("kw_valid", REDIR_VALID, 0);
      cyc();
      drive(1'b0, 1'b0, 3'b000, 26'h0, 32'h0, 6'h00);
      cyc();
      // asynchronous reset while a redirect is outstanding
      expect_br(1, 0, 32'h00000304);
      drive(1'b1, 1'b1, 3'b000, 26'h4, 32'h300, ZER);
      @(negedge CLK);
      chk("rr_accept", BR_READY, 1);
      cyc();
      drive(1'b0, 1'b0, 3'b000, 26'h0, 32'h0, 6'h00);
      @(negedge CLK);
      chk("rr_valid_pre", REDIR_VALID, 1);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("rr_valid", REDIR_VALID, 0);
      chk("rr_pc", REDIR_PC, 0);
      chk("rr_pulses", {TAKEN, FLUSH, BR_ERR}, 0);
      chk("rr_ready", BR_READY, 0);
      cyc();
      RESET_N = 1'b1;
      cyc();
      br(3'b100, 26'h0000004, 32'h00000500, POS, 1, 0, 32'h00000504);
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
